// File: rtl/mult_seq_ctrl_if.sv
// Operand/handshake/result bundle for the successive-addition multiplier.
// The master side issues start/abort and operands; the slave side is the sequencer.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic                 abort;
    logic [WIDTH-1:0]     din;
    logic                 din_valid;
    logic                 din_ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, abort, din, din_valid,
        input  din_ready, busy, done, product
    );

    modport slave (
        input  start, abort, din, din_valid,
        output din_ready, busy, done, product
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Multiply-by-successive-addition sequencer: collects A then B over a shared
// valid/ready bus, adds A into a double-width product B times, pulses done.
module mult_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_seq_ctrl_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        CHECK,
        ADD,
        DONE
    } state_t;

    typedef struct packed {
        logic busy;
        logic din_ready;
        logic done;
    } flags_t;

    // Moore output decode, applied to the state being entered so the flags are registered.
    function automatic flags_t flags_of(input state_t s);
        flags_t f;
        f.busy      = (s == GET_A) || (s == GET_B) || (s == CHECK) || (s == ADD);
        f.din_ready = (s == GET_A) || (s == GET_B);
        f.done      = (s == DONE);
        return f;
    endfunction

    state_t          state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]    product_q;
    flags_t           flags_q;

    logic             a_zero;
    logic             b_zero;
    logic             b_last;
    logic [PW-1:0]    a_ext;

    assign a_zero = (a_q == '0);
    assign b_zero = (b_q == '0);
    assign b_last = (b_q == WIDTH'(1));
    assign a_ext  = {{WIDTH{1'b0}}, a_q};

    // NOTE: every register here is a plain flop, so all of them take the reset value;
    // there is no array that would justify leaving state unreset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            flags_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the
            // pre-edge values of b_q/product_q regardless of statement order.
            case (state)
                IDLE: begin
                    if (!bus.abort && bus.start) begin
                        state     <= GET_A;
                        product_q <= '0;
                        flags_q   <= flags_of(GET_A);
                    end
                end

                GET_A: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        product_q <= '0;
                        flags_q   <= flags_of(IDLE);
                    end else if (bus.din_valid) begin
                        a_q     <= bus.din;
                        state   <= GET_B;
                        flags_q <= flags_of(GET_B);
                    end
                end

                GET_B: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        product_q <= '0;
                        flags_q   <= flags_of(IDLE);
                    end else if (bus.din_valid) begin
                        b_q     <= bus.din;
                        state   <= CHECK;
                        flags_q <= flags_of(CHECK);
                    end
                end

                CHECK: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        product_q <= '0;
                        flags_q   <= flags_of(IDLE);
                    end else if (a_zero || b_zero) begin
                        state   <= DONE;
                        flags_q <= flags_of(DONE);
                    end else begin
                        state   <= ADD;
                        flags_q <= flags_of(ADD);
                    end
                end

                ADD: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        product_q <= '0;
                        flags_q   <= flags_of(IDLE);
                    end else begin
                        product_q <= product_q + a_ext;
                        b_q       <= b_q - WIDTH'(1);
                        if (b_last) begin
                            state   <= DONE;
                            flags_q <= flags_of(DONE);
                        end
                    end
                end

                DONE: begin
                    state   <= IDLE;
                    flags_q <= flags_of(IDLE);
                end

                default: begin
                    state   <= IDLE;
                    flags_q <= flags_of(IDLE);
                end
            endcase
        end
    end

    assign bus.busy      = flags_q.busy;
    assign bus.din_ready = flags_q.din_ready;
    assign bus.done      = flags_q.done;
    assign bus.product   = product_q;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: directed scenarios with literal expectations, then random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_mult_seq_ctrl;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();
    mult_seq_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: a job is "collect A", "collect B", then a compute window whose length is
    // 1 + B edges (1 if either operand is zero), ending in a one-cycle result of A*B.
    typedef enum {M_IDLE, M_WANT_A, M_WANT_B, M_COMPUTE, M_RESULT} mphase_t;

    bit      m_valid = 1'b0;
    mphase_t m_phase = M_IDLE;
    int      m_a, m_b, m_left, m_prod;
    bit      m_prod_known;

    always @(posedge clk) begin
        if (rst_n === 1'b0) begin
            m_valid      <= 1'b1;
            m_phase      <= M_IDLE;
            m_prod       <= 0;
            m_prod_known <= 1'b1;
        end else if (m_valid) begin
            if (bus.abort && (m_phase inside {M_WANT_A, M_WANT_B, M_COMPUTE})) begin
                m_phase      <= M_IDLE;
                m_prod       <= 0;
                m_prod_known <= 1'b1;
            end else begin
                case (m_phase)
                    M_IDLE: if (bus.start && !bus.abort) begin
                        m_phase      <= M_WANT_A;
                        m_prod       <= 0;
                        m_prod_known <= 1'b1;
                    end
                    M_WANT_A: if (bus.din_valid) begin
                        m_a     <= int'(bus.din);
                        m_phase <= M_WANT_B;
                    end
                    M_WANT_B: if (bus.din_valid) begin
                        m_b          <= int'(bus.din);
                        m_left       <= (m_a == 0 || bus.din == '0) ? 1 : int'(bus.din) + 1;
                        m_phase      <= M_COMPUTE;
                        m_prod_known <= 1'b0;
                    end
                    M_COMPUTE: begin
                        if (m_left == 1) begin
                            m_phase      <= M_RESULT;
                            m_prod       <= m_a * m_b;
                            m_prod_known <= 1'b1;
                        end else begin
                            m_left <= m_left - 1;
                        end
                    end
                    M_RESULT: m_phase <= M_IDLE;
                    default:  m_phase <= M_IDLE;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", 32'(bus.busy), 32'(m_phase inside {M_WANT_A, M_WANT_B, M_COMPUTE}));
            check("din_ready", 32'(bus.din_ready), 32'(m_phase inside {M_WANT_A, M_WANT_B}));
            check("done", 32'(bus.done), 32'(m_phase == M_RESULT));
            if (m_prod_known)
                check("product", 32'(bus.product), m_prod);
        end
    end

    int done_seen = 0;
    always @(negedge clk) begin
        if (bus.done === 1'b1)
            done_seen <= done_seen + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from IDLE; lat counts edges from the B-accepting edge to the edge
    // after which done is high.
    task automatic do_mult(input logic [3:0] a, input logic [3:0] b,
                           input int stall_a, input int stall_b, input bit poke_start,
                           input int exp_lat, input int exp_prod, input string tag);
        int lat;
        int d0;
        d0 = done_seen;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (stall_a) begin
            bus.din       = 4'hF;
            bus.din_valid = 1'b0;
            step();
        end
        bus.din       = a;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        repeat (stall_b) begin
            bus.din = 4'($urandom);
            step();
        end
        bus.din       = b;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        bus.din       = '0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) break;
            if (lat >= 40) begin
                check({tag, " done timeout"}, 32'(lat), 32'(exp_lat));
                break;
            end
            bus.start = poke_start && (lat == 2);
            @(posedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " product"}, 32'(bus.product), 32'(exp_prod));
        check({tag, " model product"}, 32'(m_prod), 32'(exp_prod));
        step();
        step();
        check({tag, " done pulses"}, 32'(done_seen - d0), 32'd1);
    endtask

    // Starts 9x6 and stops after two ADD edges, leaving the caller to interrupt it.
    task automatic start_9x6();
        bus.start = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.din       = 4'd9;
        bus.din_valid = 1'b1;
        step();
        bus.din = 4'd6;
        step();
        bus.din_valid = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int d0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        step();
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset din_ready", 32'(bus.din_ready), 32'd0);
        check("reset product", 32'(bus.product), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of ADD
        d0 = done_seen;
        start_9x6();
        rst_n = 1'b0;
        step();
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        check("midreset din_ready", 32'(bus.din_ready), 32'd0);
        check("midreset product", 32'(bus.product), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (12) step();
        check("midreset no done", 32'(done_seen - d0), 32'd0);

        do_mult(4'd5, 4'd3, 0, 0, 1'b0, 4, 15, "5x3");
        do_mult(4'd15, 4'd15, 0, 0, 1'b0, 16, 225, "15x15");
        do_mult(4'd0, 4'd9, 0, 0, 1'b0, 1, 0, "0x9");
        do_mult(4'd7, 4'd0, 0, 0, 1'b0, 1, 0, "7x0");
        do_mult(4'd4, 4'd2, 3, 2, 1'b1, 3, 8, "stall 4x2");

        // Abort after two ADD edges, then recover
        d0 = done_seen;
        start_9x6();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort product", 32'(bus.product), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        repeat (3) step();
        check("abort no done", 32'(done_seen - d0), 32'd0);
        do_mult(4'd2, 4'd3, 0, 0, 1'b0, 4, 6, "2x3 after abort");

        // Random traffic, including occasional aborts and resets
        for (int i = 0; i < 1500; i++) begin
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.abort     = ($urandom_range(0, 39) == 0);
            bus.din_valid = 1'($urandom_range(0, 1));
            bus.din       = 4'($urandom);
            rst_n         = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.din_valid = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
